irq_priority_arbiter: RTL

- Parametrised, registered successor to the combinational 16-to-4 priority encoder.
- Captures request events into sticky pending bits and applies a per-channel mask.
- Selects one channel by fixed priority or round-robin, then holds a grant until the consumer acknowledges it.
- Sits between peripheral event sources (timer, keyboard, VGA vsync) and the CPU interrupt/trap logic.

---
 rtl/irq_priority_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/irq_priority_arbiter.sv
// irq_priority_arbiter: sticky, maskable interrupt request arbiter.
// Edge-captured pending bits, fixed or round-robin pick, grant held until ack.
module irq_priority_arbiter #(
  parameter int N       = 16,
  parameter int IDW     = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic           flush,
  input  logic           ack,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [N-1:0]   pending,
  output logic           any_pending
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [N-1:0]   req_q;
  logic [N-1:0]   evt;
  logic [N-1:0]   clr;
  logic [N-1:0]   elig;
  logic [N-1:0]   pend_d;
  logic           live;
  logic           hit;
  logic           gv_d;
  logic           take;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] gid_d;
  logic [IDW-1:0] rr_ptr;

  // live gates the first sample after reset so a held line is not an edge
  assign evt  = live ? (req & ~req_q) : '0;
  assign elig = pending & ~mask;
  assign take = grant_valid & ack & ~flush;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = grant_valid & ack & (grant_id == IDW'(i));
    end
  end

  assign pend_d = flush ? '0 : ((pending & ~clr) | evt);

  always_comb begin
    int k;
    k   = 0;
    sel = '0;
    hit = 1'b0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < N; i++) begin
        k = int'(rr_ptr) + i;
        if (k >= N) k = k - N;
        if (!hit && elig[k]) begin
          sel = IDW'(k);
          hit = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) begin
          sel = IDW'(i);
          hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    gv_d    = grant_valid;
    gid_d   = grant_id;
    if (flush) begin
      state_d = IDLE;
      gv_d    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state_d = GRANT;
            gv_d    = 1'b1;
            gid_d   = sel;
          end
        end
        GRANT: begin
          if (ack) begin
            state_d = IDLE;
            gv_d    = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          gv_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_d;
      grant_valid <= gv_d;
      grant_id    <= gid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      live        <= 1'b0;
      pending     <= '0;
      any_pending <= 1'b0;
    end else begin
      req_q       <= req;
      live        <= 1'b1;
      pending     <= pend_d;
      any_pending <= |elig;
    end
  end

  // explicit wrap keeps the pointer legal for non power-of-2 N
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (take) begin
      if (grant_id == IDW'(N - 1)) rr_ptr <= '0;
      else rr_ptr <= grant_id + IDW'(1);
    end
  end

endmodule
